// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_pkg
// Description : Shared constants for the Hamming(12,8) encoder and its APB
//               wrapper: register offsets, widths, parity positions and
//               STATUS/CTRL bit indices.
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    // Payload and codeword widths
    localparam int DATA_W = 8;
    localparam int CODE_W = 12;

    // Register offsets, decoded from paddr[3:2]
    localparam logic [1:0] DATA_OFS = 2'd0;
    localparam logic [1:0] CODE_OFS = 2'd1;
    localparam logic [1:0] STAT_OFS = 2'd2;
    localparam logic [1:0] CTRL_OFS = 2'd3;

    // Parity bit positions inside the codeword
    localparam int P0_POS = 0;
    localparam int P1_POS = 1;
    localparam int P2_POS = 3;
    localparam int P3_POS = 7;

    // STATUS register fields
    localparam int ST_CNT_W = 5;
    localparam int ST_EMPTY = 5;
    localparam int ST_FULL  = 6;
    localparam int ST_OVF   = 7;
    localparam int ST_UDF   = 8;

    // CTRL register fields
    localparam int CTRL_INJ_W  = 12;
    localparam int CTRL_IRQ_EN = 16;

endpackage : hamming_pkg
`default_nettype wire

// File: rtl/hamming_encode.sv
`default_nettype none
// ============================================================================
// Module      : hamming_encode
// Description : Purely combinational Hamming(12,8) encoder. Bit layout matches
//               the 12-bit Hamming decoder: parity at 0,1,3,7, data elsewhere.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_encode
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    output logic [CODE_W-1:0] o_code
);

    // Scatter data bits and compute the four parity bits
    always_comb begin
        o_code          = '0;
        o_code[2]       = i_data[0];
        o_code[4]       = i_data[1];
        o_code[5]       = i_data[2];
        o_code[6]       = i_data[3];
        o_code[8]       = i_data[4];
        o_code[9]       = i_data[5];
        o_code[10]      = i_data[6];
        o_code[11]      = i_data[7];
        o_code[P0_POS]  = i_data[0] ^ i_data[1] ^ i_data[3] ^ i_data[4] ^ i_data[6];
        o_code[P1_POS]  = i_data[0] ^ i_data[2] ^ i_data[3] ^ i_data[5] ^ i_data[6];
        o_code[P2_POS]  = i_data[1] ^ i_data[2] ^ i_data[3] ^ i_data[7];
        o_code[P3_POS]  = i_data[4] ^ i_data[5] ^ i_data[6] ^ i_data[7];
    end

endmodule : hamming_encode
`default_nettype wire

// File: rtl/hamming_encode_apb.sv
`default_nettype none
// ============================================================================
// Module      : hamming_encode_apb
// Description : APB3 slave wrapping the Hamming(12,8) encoder. DATA writes are
//               encoded, XORed with the injection mask and queued; CODE reads
//               pop the queue. STATUS exposes count/empty/full and sticky
//               overflow/underflow flags; CTRL holds INJ mask and IRQ enable.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_encode_apb
    import hamming_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 4
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              irq
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [CODE_W-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CTRL_INJ_W-1:0] r_inj;
    logic                  r_irq_en;
    logic                  r_ovf;
    logic                  r_udf;

    logic                  w_access;
    logic [1:0]            w_sel;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push_req;
    logic                  w_push;
    logic                  w_ovf_evt;
    logic                  w_pop_req;
    logic                  w_pop;
    logic                  w_udf_evt;
    logic                  w_stat_wr;
    logic                  w_ctrl_wr;
    logic [CODE_W-1:0]     w_enc;
    logic [CODE_W-1:0]     w_push_word;
    logic [31:0]           w_status;
    logic                  w_unused;

    // Access decode: a transfer completes whenever psel & penable (no waits)
    assign w_access   = psel & penable;
    assign w_sel      = paddr[3:2];
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);

    assign w_push_req = w_access &  pwrite & (w_sel == DATA_OFS);
    assign w_push     = w_push_req & ~w_full;
    assign w_ovf_evt  = w_push_req &  w_full;
    assign w_pop_req  = w_access & ~pwrite & (w_sel == CODE_OFS);
    assign w_pop      = w_pop_req & ~w_empty;
    assign w_udf_evt  = w_pop_req &  w_empty;
    assign w_stat_wr  = w_access &  pwrite & (w_sel == STAT_OFS);
    assign w_ctrl_wr  = w_access &  pwrite & (w_sel == CTRL_OFS);

    // Injection mask applied at push time, so later INJ changes leave queued words intact
    hamming_encode u_enc (
        .i_data (pwdata[DATA_W-1:0]),
        .o_code (w_enc)
    );
    assign w_push_word = w_enc ^ r_inj;

    // FIFO storage needs no reset: occupancy is tracked entirely by r_count
    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    // Pointers and occupancy counter; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // CTRL register and sticky error flags (write-1-to-clear in STATUS)
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_inj    <= '0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_inj    <= pwdata[CTRL_INJ_W-1:0];
                r_irq_en <= pwdata[CTRL_IRQ_EN];
            end
            if (w_ovf_evt) begin
                r_ovf <= 1'b1;
            end else if (w_stat_wr && pwdata[ST_OVF]) begin
                r_ovf <= 1'b0;
            end
            if (w_udf_evt) begin
                r_udf <= 1'b1;
            end else if (w_stat_wr && pwdata[ST_UDF]) begin
                r_udf <= 1'b0;
            end
        end
    end

    // STATUS word assembly
    always_comb begin
        w_status                 = '0;
        w_status[ST_CNT_W-1:0]   = ST_CNT_W'(r_count);
        w_status[ST_EMPTY]       = w_empty;
        w_status[ST_FULL]        = w_full;
        w_status[ST_OVF]         = r_ovf;
        w_status[ST_UDF]         = r_udf;
    end

    // Read mux: only drives data during a read access phase, zero otherwise
    always_comb begin
        prdata = '0;
        if (w_access && !pwrite) begin
            case (w_sel)
                CODE_OFS: begin
                    if (!w_empty) begin
                        prdata[CODE_W-1:0] = r_mem[r_rd_ptr];
                    end
                end
                STAT_OFS: prdata = w_status;
                CTRL_OFS: begin
                    prdata[CTRL_INJ_W-1:0] = r_inj;
                    prdata[CTRL_IRQ_EN]    = r_irq_en;
                end
                default:  prdata = '0;
            endcase
        end
    end

    assign pslverr = w_ovf_evt | w_udf_evt;
    assign pready  = 1'b1;
    assign irq     = ~w_empty & r_irq_en;

    // Address and data bits outside the decoded fields are intentionally ignored
    assign w_unused = &{1'b0, paddr, pwdata};

endmodule : hamming_encode_apb
`default_nettype wire

// File: tb/tb_hamming_encode_apb.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamming_encode_apb
// Description : Scoreboard bench for hamming_encode_apb. Stimulus pushes the
//               hand-computed expected response of each APB transfer into a
//               queue; a monitor pops and compares on every access phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_encode_apb;

    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 4;

    logic              pclk;
    logic              presetn;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;
    logic              irq;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        err;
        bit          chk_data;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_chk = 0;
    int   n_err = 0;

    hamming_encode_apb #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .irq     (irq)
    );

    // 100 MHz clock
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: compare every completed transfer against the scoreboard head
    always @(negedge pclk) begin
        if (presetn && psel && penable) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_transfer: addr=%h prdata=%h pslverr=%b with empty scoreboard",
                         paddr, prdata, pslverr);
            end else begin
                m_e = exp_q.pop_front();
                if (pready !== 1'b1 || pslverr !== m_e.err ||
                    (m_e.chk_data && prdata !== m_e.data)) begin
                    n_err++;
                    $display("FAIL %s: got prdata=%h pslverr=%b pready=%b, expected prdata=%h pslverr=%b",
                             m_e.name, prdata, pslverr, pready, m_e.data, m_e.err);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One APB transfer: setup phase, then access phase; expectation queued for the monitor
    task automatic apb(input bit wr, input logic [3:0] addr, input logic [31:0] wdata,
                       input string name, input logic [31:0] exp_data, input logic exp_err,
                       input bit chk_data);
        exp_t e;
        @(posedge pclk); #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(posedge pclk); #1;
        e.name     = name;
        e.data     = exp_data;
        e.err      = exp_err;
        e.chk_data = chk_data;
        exp_q.push_back(e);
        penable = 1'b1;
        @(posedge pclk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] d, input string name,
                      input logic exp_err);
        apb(1'b1, addr, d, name, 32'h0, exp_err, 1'b0);
    endtask

    task automatic rd(input logic [3:0] addr, input string name, input logic [31:0] exp_data,
                      input logic exp_err);
        apb(1'b0, addr, 32'h0, name, exp_data, exp_err, 1'b1);
    endtask

    localparam logic [3:0] A_DATA = 4'h0;
    localparam logic [3:0] A_CODE = 4'h4;
    localparam logic [3:0] A_STAT = 4'h8;
    localparam logic [3:0] A_CTRL = 4'hC;

    logic [7:0]  fill_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [11:0] fill_c [4] = '{12'h186, 12'h29B, 12'h31D, 12'h4A9};
    logic [7:0]  base_d [4] = '{8'h00, 8'hFF, 8'h01, 8'h80};
    logic [11:0] base_c [4] = '{12'h000, 12'hF77, 12'h007, 12'h888};

    initial begin
        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_prdata", prdata, 32'h0);
        check("reset_pslverr", {31'b0, pslverr}, 32'h0);
        presetn = 1'b1;

        // Reset state and underflow
        rd(A_STAT, "stat_after_reset", 32'h020, 1'b0);
        rd(A_CTRL, "ctrl_after_reset", 32'h0, 1'b0);
        rd(A_CODE, "code_underflow", 32'h0, 1'b1);
        rd(A_STAT, "stat_udf_set", 32'h120, 1'b0);
        wr(A_STAT, 32'h100, "clear_udf", 1'b0);
        rd(A_STAT, "stat_udf_clear", 32'h020, 1'b0);

        // Basic encodes, fill to full, drain in order
        for (int i = 0; i < 4; i++) wr(A_DATA, {24'h0, base_d[i]}, "data_base", 1'b0);
        rd(A_STAT, "stat_full", 32'h044, 1'b0);
        for (int i = 0; i < 4; i++) rd(A_CODE, $sformatf("code_base%0d", i), {20'h0, base_c[i]}, 1'b0);
        rd(A_STAT, "stat_drained", 32'h020, 1'b0);

        // Encode of 0xA5
        wr(A_DATA, 32'hA5, "data_a5", 1'b0);
        rd(A_CODE, "code_a5", 32'hA27, 1'b0);

        // Error injection sampled per push
        wr(A_CTRL, 32'h004, "ctrl_inj", 1'b0);
        rd(A_CTRL, "ctrl_inj_rb", 32'h004, 1'b0);
        wr(A_DATA, 32'hA5, "data_a5_inj", 1'b0);
        wr(A_CTRL, 32'h000, "ctrl_inj_clr", 1'b0);
        wr(A_DATA, 32'hA5, "data_a5_clean", 1'b0);
        rd(A_CODE, "code_a5_inj", 32'hA23, 1'b0);
        rd(A_CODE, "code_a5_clean", 32'hA27, 1'b0);

        // Overflow: 5th write dropped, originals preserved in order
        for (int i = 0; i < 4; i++) wr(A_DATA, {24'h0, fill_d[i]}, "data_fill", 1'b0);
        wr(A_DATA, 32'h3C, "data_overflow", 1'b1);
        rd(A_STAT, "stat_ovf_full", 32'h0C4, 1'b0);
        for (int i = 0; i < 4; i++) rd(A_CODE, $sformatf("code_fill%0d", i), {20'h0, fill_c[i]}, 1'b0);
        rd(A_STAT, "stat_ovf_empty", 32'h0A0, 1'b0);
        wr(A_STAT, 32'h080, "clear_ovf", 1'b0);
        rd(A_STAT, "stat_ovf_clear", 32'h020, 1'b0);

        // Illegal write to CODE has no effect
        wr(A_CODE, 32'h123, "write_code", 1'b0);
        rd(A_STAT, "stat_after_code_wr", 32'h020, 1'b0);

        // Interrupt and mid-operation reset
        wr(A_CTRL, 32'h10000, "ctrl_irq_en", 1'b0);
        check("irq_idle_empty", {31'b0, irq}, 32'h0);
        wr(A_DATA, 32'h5A, "data_irq", 1'b0);
        check("irq_after_push", {31'b0, irq}, 32'h1);
        rd(A_CTRL, "ctrl_irq_rb", 32'h10000, 1'b0);
        wr(A_DATA, 32'h5B, "data_before_reset", 1'b0);
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        check("irq_in_reset", {31'b0, irq}, 32'h0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        check("irq_after_reset", {31'b0, irq}, 32'h0);
        rd(A_STAT, "stat_after_midreset", 32'h020, 1'b0);
        rd(A_CTRL, "ctrl_after_midreset", 32'h0, 1'b0);
        rd(A_CODE, "code_after_midreset", 32'h0, 1'b1);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge pclk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_hamming_encode_apb
`default_nettype wire

// File: doc/hamming_encode_apb.md
Name: hamming_encode_apb

Overview:
APB3 slave that takes 8-bit payload writes and Hamming(12,8)-encodes them. Encoded words are queued in a small FIFO and read back over APB, giving software the encode path of the Hamming ECC block. Its codeword layout is bit-exact with the team's 12-bit Hamming decoder. A programmable error-injection mask lets software corrupt codewords on purpose, to exercise decoder correction.

Parameters:
FIFO_DEPTH, 4, number of encoded words buffered; power of two, 2..16
ADDR_W, 4, width of paddr

Ports:
pclk  in  1  APB clock; the only clock
presetn  in  1  asynchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_W  byte address; only [3:2] decoded
pwdata  in  32  write data
prdata  out  32  read data
pready  out  1  tied 1 (zero wait states)
pslverr  out  1  error response
irq  out  1  level interrupt = fifo_not_empty & IRQ_EN

Behaviour:
- Reset (presetn=0, async assert, sync release): FIFO empty, count=0, pointers=0, INJ=0, IRQ_EN=0, sticky flags=0, prdata=0, pslverr=0, irq=0.
- A transfer completes in the cycle with psel & penable. pready is always 1.
- Register map by paddr[3:2]:
  - 0x0 DATA (W): pwdata[7:0] is encoded, XORed with INJ[11:0], then pushed. Reads return 0.
  - 0x4 CODE (R): prdata[11:0] = FIFO head; the word is popped on that access cycle. Upper bits are 0. Writes are ignored.
  - 0x8 STATUS (R): [4:0] count, [5] empty, [6] full, [7] OVF sticky, [8] UDF sticky. Writing 1 to [7]/[8] clears that flag.
  - 0xC CTRL (RW): [11:0] INJ mask, [16] IRQ_EN.
- Encoding, with d = data[7:0] and c = code[11:0]:
  - Data bits: c2=d0, c4=d1, c5=d2, c6=d3, c8=d4, c9=d5, c10=d6, c11=d7.
  - Parity bits: c0=d0^d1^d3^d4^d6; c1=d0^d2^d3^d5^d6; c3=d1^d2^d3^d7; c7=d4^d5^d6^d7.
- Latency: a word pushed by a DATA write is readable at CODE from the next APB transfer onward.
- Full: a DATA write when count==FIFO_DEPTH is dropped. That access returns pslverr=1, sets OVF, and FIFO and pointers stay unchanged.
- Empty: a CODE read when count==0 returns prdata=0 and pslverr=1, sets UDF, and no pointer moves.
- Pointers wrap modulo FIFO_DEPTH. Count is a separate counter of width $clog2(FIFO_DEPTH)+1.
- pslverr and prdata are driven combinationally during the access phase only, and are 0 otherwise.
- INJ is sampled at push time. Changing INJ later does not alter words already queued.
- Reset mid-operation discards all queued words immediately.
- Unmapped or illegal accesses (write to CODE, write to STATUS bits other than [7]/[8]) have no effect and give pslverr=0.

Decomposition:
- hamming_pkg:
  - Register offsets: DATA_OFS, CODE_OFS, STAT_OFS, CTRL_OFS.
  - Widths: DATA_W=8, CODE_W=12.
  - Parity positions: 0, 1, 3, 7.
  - STATUS bit-index constants.
- Sub-module hamming_encode: purely combinational 8→12 encoder, shared by any future stream encoder.
- Top level holds the APB decode, FIFO storage and pointers, counter, and CSRs.

Test Plan:
- After reset, read STATUS → 0x020 (empty). Read CODE → prdata=0, pslverr=1, then STATUS=0x120.
- Write DATA 0x00, 0xFF, 0x01, 0x80 → STATUS count=4, full → 0x044. Read CODE four times → 0x000, 0xF77, 0x007, 0x888, then empty.
- Write DATA 0xA5 → CODE 0xA27. Feed 0xA27 to hamming_decode → decoded_data=0xA5, verify_bit=0.
- Set CTRL INJ=0x004, write DATA 0xA5 → CODE 0xA23. Clear INJ, write 0xA5 → CODE 0xA27 (INJ sampled per push).
- Fill FIFO to 4 words, write a 5th DATA 0x3C → pslverr=1, OVF set. The four original words read back in order and 0x3C is absent. Write STATUS 0x080 → OVF clears.
- Set IRQ_EN, write one word → irq=1 from the next cycle. Assert presetn=0 mid-sequence → irq=0, STATUS=0x020, CTRL=0 immediately.
